// File: rtl/zx8x_tape_pkg.sv
// Shared types and timing defaults for the ZX80/ZX81 cassette pulse generator.
// Timing values are in ce ticks (3.25 MHz).
package zx8x_tape_pkg;

  localparam int PULSE_HI_DEF = 488;
  localparam int PULSE_LO_DEF = 488;
  localparam int BIT_GAP_DEF  = 4225;
  localparam int LEADER_DEF   = 3250000;
  localparam logic [7:0] NAME_BYTE_DEF = 8'h80;

  localparam logic [3:0] ONE_PULSES  = 4'd9;
  localparam logic [3:0] ZERO_PULSES = 4'd4;

  localparam int TICK_W = 13;
  localparam int LEAD_W = 22;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEADER, ST_FETCH, ST_LOAD, ST_BIT, ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE, PH_HI, PH_LO, PH_GAP
  } phase_t;

  function automatic logic [3:0] pulses_for(input logic b);
    return b ? ONE_PULSES : ZERO_PULSES;
  endfunction

endpackage

// File: rtl/zx8x_tape_pulse_gen.sv
// One tape bit: count HI/LO pulse pairs then BIT_GAP of silence; bit_done on the final gap ce.
// A start during that same ce chains straight into the next bit with no dead cycle.
module zx8x_tape_pulse_gen
  import zx8x_tape_pkg::*;
#(
  parameter int PULSE_HI = PULSE_HI_DEF,
  parameter int PULSE_LO = PULSE_LO_DEF,
  parameter int BIT_GAP  = BIT_GAP_DEF
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       abort,
  input  logic       start,
  input  logic [3:0] count,
  output logic       hi,
  output logic       bit_done
);

  localparam logic [TICK_W-1:0] HI_LD  = TICK_W'(PULSE_HI - 1);
  localparam logic [TICK_W-1:0] LO_LD  = TICK_W'(PULSE_LO - 1);
  localparam logic [TICK_W-1:0] GAP_LD = TICK_W'(BIT_GAP - 1);

  phase_t            ph, ph_nx;
  logic [TICK_W-1:0] tick_cnt, tick_nx;
  logic [3:0]        pulse_cnt, pulse_nx;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ph        <= PH_IDLE;
      tick_cnt  <= '0;
      pulse_cnt <= '0;
    end else begin
      ph        <= ph_nx;
      tick_cnt  <= tick_nx;
      pulse_cnt <= pulse_nx;
    end
  end

  always_comb begin
    ph_nx    = ph;
    tick_nx  = tick_cnt;
    pulse_nx = pulse_cnt;
    bit_done = 1'b0;
    case (ph)
      PH_IDLE: if (start) begin
        ph_nx    = PH_HI;
        tick_nx  = HI_LD;
        pulse_nx = count - 4'd1;
      end
      PH_HI: if (ce) begin
        if (tick_cnt == '0) begin
          ph_nx   = PH_LO;
          tick_nx = LO_LD;
        end else begin
          tick_nx = tick_cnt - TICK_W'(1);
        end
      end
      PH_LO: if (ce) begin
        if (tick_cnt != '0) begin
          tick_nx = tick_cnt - TICK_W'(1);
        end else if (pulse_cnt == 4'd0) begin
          ph_nx   = PH_GAP;
          tick_nx = GAP_LD;
        end else begin
          ph_nx    = PH_HI;
          tick_nx  = HI_LD;
          pulse_nx = pulse_cnt - 4'd1;
        end
      end
      PH_GAP: if (ce) begin
        if (tick_cnt != '0) begin
          tick_nx = tick_cnt - TICK_W'(1);
        end else begin
          bit_done = 1'b1;
          if (start) begin
            ph_nx    = PH_HI;
            tick_nx  = HI_LD;
            pulse_nx = count - 4'd1;
          end else begin
            ph_nx = PH_IDLE;
          end
        end
      end
      default: ph_nx = PH_IDLE;
    endcase
    if (abort) begin
      ph_nx    = PH_IDLE;
      tick_nx  = '0;
      pulse_nx = '0;
      bit_done = 1'b0;
    end
  end

  assign hi = (ph == PH_HI);

endmodule

// File: rtl/zx8x_tape_player.sv
// Replays tape_ram as ZX80/ZX81 cassette pulses: leader, optional name byte, then data MSB first.
// Memory read is one clk (FETCH) ahead of LOAD; stop or loss of tape_ready aborts on the next clk.
module zx8x_tape_player
  import zx8x_tape_pkg::*;
#(
  parameter int         PULSE_HI  = PULSE_HI_DEF,
  parameter int         PULSE_LO  = PULSE_LO_DEF,
  parameter int         BIT_GAP   = BIT_GAP_DEF,
  parameter int         LEADER    = LEADER_DEF,
  parameter logic [7:0] NAME_BYTE = NAME_BYTE_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        zx81,
  input  logic        tape_ready,
  input  logic [13:0] tape_last,
  input  logic        play,
  input  logic        stop,
  output logic [13:0] tape_rd_addr,
  input  logic [7:0]  tape_rd_data,
  output logic        tape_out,
  output logic        playing,
  output logic        done
);

  state_t            state, state_nx;
  logic [LEAD_W-1:0] lead_cnt, lead_nx;
  logic [13:0]       byte_addr, addr_nx, last_addr, last_nx;
  logic              zx81_q, zx81_nx, first_byte, first_nx;
  logic [7:0]        shift_reg, shift_nx, load_byte;
  logic [2:0]        bit_cnt, bit_nx;
  logic              abort, pg_start, pg_done;
  logic [3:0]        pg_count;

  assign abort = stop || !tape_ready;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      lead_cnt   <= '0;
      byte_addr  <= '0;
      last_addr  <= '0;
      zx81_q     <= 1'b0;
      first_byte <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
    end else begin
      state      <= state_nx;
      lead_cnt   <= lead_nx;
      byte_addr  <= addr_nx;
      last_addr  <= last_nx;
      zx81_q     <= zx81_nx;
      first_byte <= first_nx;
      shift_reg  <= shift_nx;
      bit_cnt    <= bit_nx;
    end
  end

  // first_byte stays set through the name byte so its end does not advance byte_addr
  assign load_byte = (zx81_q && first_byte) ? NAME_BYTE : tape_rd_data;

  always_comb begin
    state_nx = state;
    lead_nx  = lead_cnt;
    addr_nx  = byte_addr;
    last_nx  = last_addr;
    zx81_nx  = zx81_q;
    first_nx = first_byte;
    shift_nx = shift_reg;
    bit_nx   = bit_cnt;
    pg_start = 1'b0;
    pg_count = ZERO_PULSES;
    case (state)
      ST_IDLE: if (play && tape_ready) begin
        state_nx = ST_LEADER;
        lead_nx  = LEAD_W'(LEADER - 1);
        addr_nx  = '0;
        last_nx  = tape_last;
        zx81_nx  = zx81;
        first_nx = 1'b1;
      end
      ST_LEADER: if (ce) begin
        if (lead_cnt == '0) state_nx = ST_FETCH;
        else                lead_nx  = lead_cnt - LEAD_W'(1);
      end
      ST_FETCH: state_nx = ST_LOAD;
      ST_LOAD: begin
        shift_nx = load_byte;
        bit_nx   = 3'd7;
        first_nx = zx81_q && first_byte;
        pg_start = 1'b1;
        pg_count = pulses_for(load_byte[7]);
        state_nx = ST_BIT;
      end
      ST_BIT: if (pg_done) begin
        if (bit_cnt != 3'd0) begin
          shift_nx = {shift_reg[6:0], 1'b0};
          bit_nx   = bit_cnt - 3'd1;
          pg_start = 1'b1;
          pg_count = pulses_for(shift_reg[6]);
        end else if (first_byte) begin
          first_nx = 1'b0;
          state_nx = ST_FETCH;
        end else if (byte_addr == last_addr) begin
          state_nx = ST_FIN;
        end else begin
          addr_nx  = byte_addr + 14'd1;
          state_nx = ST_FETCH;
        end
      end
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  zx8x_tape_pulse_gen #(
    .PULSE_HI (PULSE_HI),
    .PULSE_LO (PULSE_LO),
    .BIT_GAP  (BIT_GAP)
  ) u_pulse_gen (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ce       (ce),
    .abort    (abort),
    .start    (pg_start),
    .count    (pg_count),
    .hi       (tape_out),
    .bit_done (pg_done)
  );

  assign tape_rd_addr = byte_addr;
  assign playing      = (state != ST_IDLE) && (state != ST_FIN);
  assign done         = (state == ST_FIN);

endmodule
